// File: rtl/led_sensor_io_pkg.sv
// rtl/led_sensor_io_pkg.sv - opcodes, FSM states and reset constants for led_sensor_io
package led_sensor_io_pkg;

  typedef enum logic [1:0] {
    OP_LED_WR    = 2'b00,
    OP_CAP_RD    = 2'b01,
    OP_HIT_RDCLR = 2'b10,
    OP_THR_WR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Threshold reset value: nothing can compare >= all-ones except all-ones itself.
  localparam logic [31:0] THR_RST = 32'hFFFF_FFFF;

  localparam int CNT_W = 2;

endpackage

// File: rtl/led_sensor_io_if.sv
// rtl/led_sensor_io_if.sv - request/response handshake bundle between execute and led_sensor_io
interface led_sensor_io_if #(
  parameter int CH_W = 4
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [CH_W-1:0] req_ch;
  logic [31:0]     req_data;
  logic            busy;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_ch, req_data,
    input  busy, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_ch, req_data,
    output busy, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/led_sensor_io_sensor_sync.sv
// rtl/led_sensor_io_sensor_sync.sv - multi-flop synchroniser for one asynchronous sensor word
module sensor_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/led_sensor_io.sv
// rtl/led_sensor_io.sv - LED command / capacitive sensor I/O unit; LED_SENSOR_IO_IRQ_EN adds irq_mask/irq
module led_sensor_io
  import led_sensor_io_pkg::*;
#(
  parameter int NUM_CH      = 9,
  parameter int LED_W       = 16,
  parameter int SENS_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  led_sensor_io_if.slave           bus,
  input  logic [NUM_CH*SENS_W-1:0] sensor_readings,
  output logic [NUM_CH*LED_W-1:0]  led_commands,
  output logic [NUM_CH-1:0]        hit_flags
`ifdef LED_SENSOR_IO_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]        irq_mask,
  output logic                     irq
`endif
);

  logic [NUM_CH-1:0][SENS_W-1:0] sync;
  logic [NUM_CH-1:0][LED_W-1:0]  led_q,  led_d;
  logic [NUM_CH-1:0][SENS_W-1:0] thr_q,  thr_d;
  logic [NUM_CH-1:0]             hit_q,  hit_d;

  state_e          state_q;
  op_e             op_q;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;

  op_e             req_op;
  logic [CH_W-1:0] req_ch;
  logic            req_ch_ok;
  logic            ch_ok;
  logic            accept;
  logic            resp_edge;
  logic            hit_clr;
  logic [31:0]     rd_data;
  logic            unused_req_data;

  assign req_op          = op_e'(bus.req_op);
  assign req_ch          = bus.req_ch;
  assign req_ch_ok       = 32'(req_ch) < NUM_CH;
  assign ch_ok           = 32'(ch_q) < NUM_CH;
  assign accept          = (state_q == ST_IDLE) && bus.req_valid;
  assign resp_edge       = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
  assign hit_clr         = resp_edge && (op_q == OP_HIT_RDCLR);
  assign unused_req_data = ^bus.req_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    sensor_sync #(
      .WIDTH (SENS_W),
      .DEPTH (SYNC_STAGES)
    ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (sensor_readings[k*SENS_W +: SENS_W]),
      .q_o     (sync[k])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        rd_data = (op_q == OP_CAP_RD) ? 32'(sync[k]) : {31'b0, hit_q[k]};
      end
    end
  end

  // Out-of-range channels never match any k, so bad writes fall through untouched.
  always_comb begin
    led_d = led_q;
    thr_d = thr_q;
    hit_d = hit_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (accept && req_ch == CH_W'(k)) begin
        if (req_op == OP_LED_WR) led_d[k] = bus.req_data[LED_W-1:0];
        if (req_op == OP_THR_WR) thr_d[k] = bus.req_data[SENS_W-1:0];
      end
      if (hit_clr && ch_q == CH_W'(k)) hit_d[k] = 1'b0;
      if (sync[k] >= thr_q[k])         hit_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
      thr_q <= {NUM_CH{THR_RST[SENS_W-1:0]}};
      hit_q <= '0;
    end else begin
      led_q <= led_d;
      thr_q <= thr_d;
      hit_q <= hit_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LED_WR;
      ch_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            case (req_op)
              OP_LED_WR, OP_THR_WR: rsp_err_q <= !req_ch_ok;
              default: begin
                op_q    <= req_op;
                ch_q    <= req_ch;
                cnt_q   <= CNT_W'(SYNC_STAGES - 1);
                busy_q  <= 1'b1;
                state_q <= ST_WAIT;
              end
            endcase
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Counter reaching zero on this edge: response registers load now.
          if (resp_edge) begin
            state_q     <= ST_RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !ch_ok;
            rsp_data_q  <= ch_ok ? rd_data : 32'd0;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign led_commands  = led_q;
  assign hit_flags     = hit_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef LED_SENSOR_IO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(hit_q & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_led_sensor_io.sv
// tb/tb_led_sensor_io.sv - self-checking bench for led_sensor_io (vector table + response scoreboard)
module tb_led_sensor_io;
  import led_sensor_io_pkg::*;

  localparam int NUM_CH = 9;
  localparam int LED_W  = 16;
  localparam int SENS_W = 32;
  localparam int SS     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_sensor_io_if #(.CH_W(4)) bus ();
  logic [NUM_CH*SENS_W-1:0] sens;
  logic [NUM_CH*LED_W-1:0]  leds;
  logic [NUM_CH-1:0]        hits;
`ifdef LED_SENSOR_IO_IRQ_EN
  logic [NUM_CH-1:0]        irq_mask;
  logic                     irq;
`endif

  led_sensor_io #(
    .NUM_CH      (NUM_CH),
    .LED_W       (LED_W),
    .SENS_W      (SENS_W),
    .SYNC_STAGES (SS),
    .CH_W        (4)
  ) dut (
    .clock           (clk),
    .reset_n         (rst_n),
    .bus             (bus),
    .sensor_readings (sens),
    .led_commands    (leds),
    .hit_flags       (hits)
`ifdef LED_SENSOR_IO_IRQ_EN
    ,
    .irq_mask        (irq_mask),
    .irq             (irq)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  ch;
    logic [31:0] data;
    logic [31:0] exp_rsp;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t  vecs[10];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    total   = 0;
  int    bad     = 0;
  int    rsp_cnt = 0;
  int    rcnt;
  logic [NUM_CH*LED_W-1:0] led_model;

  task automatic check(input string name, input logic [NUM_CH*LED_W-1:0] act,
                       input logic [NUM_CH*LED_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data=%h err=%b want no response", bus.rsp_data, bus.rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, mon_e.data);
        check("rsp_err", bus.rsp_err, mon_e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] op, input logic [3:0] ch,
                          input logic [31:0] d, input logic exp_err);
    bus.req_op    = op;
    bus.req_ch    = ch;
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("wr_err_pulse", bus.rsp_err, exp_err);
    check("wr_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    check("wr_err_clear", bus.rsp_err, 1'b0);
  endtask

  task automatic do_read(input logic [1:0] op, input logic [3:0] ch,
                         input logic [31:0] exp_data, input logic exp_err);
    int n;
    exp_q.push_back('{data: exp_data, err: exp_err});
    bus.req_op    = op;
    bus.req_ch    = ch;
    bus.req_data  = 32'd0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      tick();
      n++;
    end
    check("rd_latency", n, SS - 1);
    tick();
  endtask

  initial begin
    vecs[0] = '{OP_LED_WR,    4'd0,  32'h0000_ABCD, 32'd0,         1'b0};
    vecs[1] = '{OP_LED_WR,    4'd8,  32'h0000_1234, 32'd0,         1'b0};
    vecs[2] = '{OP_LED_WR,    4'd9,  32'h0000_FFFF, 32'd0,         1'b1};
    vecs[3] = '{OP_CAP_RD,    4'd3,  32'd0,         32'h0000_0500, 1'b0};
    vecs[4] = '{OP_CAP_RD,    4'd12, 32'd0,         32'd0,         1'b1};
    vecs[5] = '{OP_LED_WR,    4'd4,  32'hDEAD_5A5A, 32'd0,         1'b0};
    vecs[6] = '{OP_CAP_RD,    4'd7,  32'd0,         32'h0000_1777, 1'b0};
    vecs[7] = '{OP_THR_WR,    4'd11, 32'd0,         32'd0,         1'b1};
    vecs[8] = '{OP_HIT_RDCLR, 4'd1,  32'd0,         32'd0,         1'b0};
    vecs[9] = '{OP_LED_WR,    4'd0,  32'h0000_0F0F, 32'd0,         1'b0};

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_ch    = 4'd0;
    bus.req_data  = 32'd0;
    for (int k = 0; k < NUM_CH; k++) sens[k*SENS_W +: SENS_W] = 32'h0000_1000 + 32'h111 * k;
    sens[3*SENS_W +: SENS_W] = 32'h0000_0500;
    sens[5*SENS_W +: SENS_W] = 32'h0000_0000;
    led_model = '0;
`ifdef LED_SENSOR_IO_IRQ_EN
    irq_mask = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", leds, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_hits", hits, '0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].op == OP_CAP_RD || vecs[i].op == OP_HIT_RDCLR) begin
        do_read(vecs[i].op, vecs[i].ch, vecs[i].exp_rsp, vecs[i].exp_err);
      end else begin
        do_write(vecs[i].op, vecs[i].ch, vecs[i].data, vecs[i].exp_err);
        if (vecs[i].op == OP_LED_WR && vecs[i].ch < 4'd9)
          led_model[int'(vecs[i].ch)*LED_W +: LED_W] = vecs[i].data[LED_W-1:0];
        check("led_state", leds, led_model);
      end
    end

    // Exact latency, and a request held during busy must be dropped.
    rcnt = rsp_cnt;
    exp_q.push_back('{data: 32'h0000_0500, err: 1'b0});
    bus.req_op    = OP_CAP_RD;
    bus.req_ch    = 4'd3;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    check("lat_busy", bus.busy, 1'b1);
    check("lat_no_rsp_yet", bus.rsp_valid, 1'b0);
    bus.req_ch = 4'd0;
    tick();
    check("lat_rsp_valid", bus.rsp_valid, 1'b1);
    check("lat_busy_low", bus.busy, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    check("busy_req_ignored", rsp_cnt, rcnt + 1);

    do_write(OP_THR_WR, 4'd5, 32'h0000_0400, 1'b0);
    sens[5*SENS_W +: SENS_W] = 32'h0000_03FF;
    repeat (5) tick();
    check("below_thr", hits, '0);
    sens[5*SENS_W +: SENS_W] = 32'h0000_0400;
    tick();
    check("hit_not_yet", hits[5], 1'b0);
    tick();
    tick();
    check("hit_set", hits, 9'h020);
    sens[5*SENS_W +: SENS_W] = 32'h0000_0000;
    repeat (4) tick();
    check("hit_sticky", hits[5], 1'b1);
    do_read(OP_HIT_RDCLR, 4'd5, 32'd1, 1'b0);
    check("hit_cleared", hits[5], 1'b0);
    sens[5*SENS_W +: SENS_W] = 32'h0000_0400;
    repeat (4) tick();
    check("hit_reset", hits[5], 1'b1);
    do_read(OP_HIT_RDCLR, 4'd5, 32'd1, 1'b0);
    check("set_wins", hits[5], 1'b1);

`ifdef LED_SENSOR_IO_IRQ_EN
    irq_mask = 9'h020;
    tick();
    check("irq_on", irq, 1'b1);
    irq_mask = 9'h000;
    tick();
    check("irq_off", irq, 1'b0);
`endif

    // Reset while a read is outstanding.
    bus.req_op    = OP_CAP_RD;
    bus.req_ch    = 4'd2;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("mid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_leds", leds, '0);
    check("mid_rst_hits", hits, '0);
    rcnt = rsp_cnt;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("no_rsp_after_rst", rsp_cnt, rcnt);
    check("thr_reset_no_hit", hits, '0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
